// File: rtl/vga_mux4.sv
// ============================================================================
// Module   : vga_mux4
// Purpose  : Registered 4:1 quadrant colour selector for the VGA pixel path.
//            Optional blanking input enabled by defining VGA_MUX4_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_mux4 #(
    parameter int unsigned      WIDTH       = 24,
    parameter logic [WIDTH-1:0] RESET_COLOR = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    input  logic [WIDTH-1:0] r4,
    input  logic [1:0]       s,
`ifdef VGA_MUX4_BLANK_EN
    input  logic             blank,
`endif
    output logic [WIDTH-1:0] color
);

    logic [WIDTH-1:0] color_q;
    logic [WIDTH-1:0] color_d;
    logic [WIDTH-1:0] w_sel;

    // Unknown selects must yield X rather than silently falling back to r1.
    always_comb begin
        w_sel = 'x;
        case (s)
            2'b00:   w_sel = r1;
            2'b01:   w_sel = r2;
            2'b10:   w_sel = r3;
            2'b11:   w_sel = r4;
            default: w_sel = 'x;
        endcase
    end

    always_comb begin
        color_d = color_q;
        if (en) begin
`ifdef VGA_MUX4_BLANK_EN
            color_d = blank ? '0 : w_sel;
`else
            color_d = w_sel;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_q <= RESET_COLOR;
        end else begin
            color_q <= color_d;
        end
    end

    assign color = color_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_mux4.sv
// ============================================================================
// Module   : tb_vga_mux4
// Purpose  : Self-checking bench for vga_mux4 (directed vectors plus model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_mux4;

    localparam int unsigned W = 24;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] r1, r2, r3, r4;
    logic [1:0]   s;
`ifdef VGA_MUX4_BLANK_EN
    logic         blank;
`endif
    logic [W-1:0] color;

    int n_checks;
    int n_fail;
    bit chk_en;
    logic [W-1:0] exp_color;

    vga_mux4 #(.WIDTH(W), .RESET_COLOR('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .r1    (r1),
        .r2    (r2),
        .r3    (r3),
        .r4    (r4),
        .s     (s),
`ifdef VGA_MUX4_BLANK_EN
        .blank (blank),
`endif
        .color (color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: register holds the quadrant colour chosen at the last enabled edge.
    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] quad [4];
        quad = '{r1, r2, r3, r4};
        if (!rst_n) begin
            exp_color = '0;
        end else if (en) begin
            exp_color = quad[s];
`ifdef VGA_MUX4_BLANK_EN
            if (blank) exp_color = '0;
`endif
        end
    end

    always @(negedge clk) begin
        if (chk_en) check("model", color, exp_color);
    end

    task automatic drive(input logic e, input logic [1:0] sel);
        @(negedge clk);
        en = e;
        s  = sel;
    endtask

    task automatic edge_check(input string name, input logic [W-1:0] req);
        @(posedge clk);
        #1;
        check(name, color, req);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        rst_n    = 1'b1;
        en       = 1'b0;
        s        = 2'b00;
        r1 = 24'h000000; r2 = 24'h000FFF; r3 = 24'hFFF000; r4 = 24'hFFFFFF;
`ifdef VGA_MUX4_BLANK_EN
        blank = 1'b0;
`endif
        // Asynchronous assertion in mid-cycle, no clock edge involved.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_async", color, 24'h000000);
        edge_check("reset_hold", 24'h000000);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Quadrant sweep.
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] sweep [4];
            sweep = '{24'h000000, 24'h000FFF, 24'hFFF000, 24'hFFFFFF};
            drive(1'b1, 2'(i));
            edge_check("sweep", sweep[i]);
        end

        // Hold while disabled.
        drive(1'b1, 2'b10);
        edge_check("hold_load", 24'hFFF000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b11);
            edge_check("hold", 24'hFFF000);
        end
        drive(1'b1, 2'b11);
        edge_check("hold_release", 24'hFFFFFF);

        // Fixed select, data changes.
        drive(1'b1, 2'b01);
        edge_check("r2_base", 24'h000FFF);
        @(negedge clk) r2 = 24'h123456;
        edge_check("r2_follow", 24'h123456);
        @(negedge clk) begin r1 = 24'hAAAAAA; r3 = 24'h555555; r4 = 24'h0F0F0F; end
        edge_check("others_ignored", 24'h123456);
        @(negedge clk) begin r1 = 24'h000000; r3 = 24'hFFF000; r4 = 24'hFFFFFF; r2 = 24'h000FFF; end

`ifdef VGA_MUX4_BLANK_EN
        @(negedge clk) begin en = 1'b1; s = 2'b11; blank = 1'b1; end
        edge_check("blank_on", 24'h000000);
        @(negedge clk) blank = 1'b0;
        edge_check("blank_off", 24'hFFFFFF);
        @(negedge clk) begin en = 1'b0; blank = 1'b1; end
        edge_check("blank_hold", 24'hFFFFFF);
        @(negedge clk) blank = 1'b0;
`endif

        // Reset mid-stream.
        drive(1'b1, 2'b11);
        edge_check("pre_reset", 24'hFFFFFF);
        #2 rst_n = 1'b0;
        #1 check("midreset_async", color, 24'h000000);
        edge_check("midreset_hold", 24'h000000);
        @(negedge clk) begin rst_n = 1'b1; s = 2'b01; en = 1'b1; end
        edge_check("post_reset", 24'h000FFF);

        // Varied traffic, checked by the model only.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 3) != 0);
            s  = 2'($urandom_range(0, 3));
            r1 = W'($urandom); r2 = W'($urandom);
            r3 = W'($urandom); r4 = W'($urandom);
`ifdef VGA_MUX4_BLANK_EN
            blank = ($urandom_range(0, 4) == 0);
`endif
        end
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
